// File: rtl/exe_scheduler.sv
// Two-port round-robin front end for a registered execution unit: arbitrates
// commands, sequences DRIVE/CAPTURE, and returns tagged, backpressured responses.
`ifndef OVF_BIT
`define OVF_BIT 0
`endif
`ifndef ERROR_BIT
`define ERROR_BIT 1
`endif
`ifndef EVEN_BIT
`define EVEN_BIT 2
`endif
`ifndef SINGLE_BIT
`define SINGLE_BIT 3
`endif

module exe_scheduler #(
    parameter int BITS  = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    input  logic [BITS-1:0]  i_req_a0,
    input  logic [BITS-1:0]  i_req_a1,
    input  logic [BITS-1:0]  i_req_b0,
    input  logic [BITS-1:0]  i_req_b1,
    input  logic [1:0]       i_req_op0,
    input  logic [1:0]       i_req_op1,
    output logic [1:0]       o_req_ready,
    output logic [BITS-1:0]  o_exe_a,
    output logic [BITS-1:0]  o_exe_b,
    output logic [1:0]       o_exe_op,
    input  logic [BITS-1:0]  i_exe_out,
    input  logic [3:0]       i_exe_status,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [BITS-1:0]  o_rsp_data,
    output logic [3:0]       o_rsp_status,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_win;
    logic [BITS-1:0]  w_sel_a;
    logic [BITS-1:0]  w_sel_b;
    logic [1:0]       w_sel_op;
    logic             w_rsp_done;
    logic             w_err_inc;

    logic             r_rr_ptr;
    logic [BITS-1:0]  r_exe_a;
    logic [BITS-1:0]  r_exe_b;
    logic [1:0]       r_exe_op;
    logic             r_id;
    logic [BITS-1:0]  r_rsp_data;
    logic [3:0]       r_rsp_status;
    logic             r_rsp_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_err_cnt;

    // Grant is gated by reset so no command is seen as accepted during a reset cycle.
    always_comb begin
        w_grant = '0;
        if (!i_rst && r_state == S_IDLE) begin
            case (i_req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                default: w_grant = '0;
            endcase
        end
    end

    assign w_accept = |w_grant;
    assign w_win    = w_grant[1];

    always_comb begin
        w_sel_a  = i_req_a0;
        w_sel_b  = i_req_b0;
        w_sel_op = i_req_op0;
        if (w_win) begin
            w_sel_a  = i_req_a1;
            w_sel_b  = i_req_b1;
            w_sel_op = i_req_op1;
        end
    end

    assign w_rsp_done = (r_state == S_RESP) && i_rsp_ready;
    assign w_err_inc  = w_rsp_done && r_rsp_status[`ERROR_BIT] && !(&r_err_cnt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_DRIVE;
            S_DRIVE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP:    if (i_rsp_ready) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr     <= 1'b0;
            r_exe_a      <= '0;
            r_exe_b      <= '0;
            r_exe_op     <= '0;
            r_id         <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_exe_a  <= w_sel_a;
                r_exe_b  <= w_sel_b;
                r_exe_op <= w_sel_op;
                r_id     <= w_win;
                r_rr_ptr <= ~w_win;
            end
            if (r_state == S_CAPTURE) begin
                r_rsp_data   <= i_exe_out;
                r_rsp_status <= i_exe_status;
            end
            // Valid and busy are registered from the next state so they align with RESP / non-IDLE.
            r_rsp_valid <= (w_next == S_RESP);
            r_busy      <= (w_next != S_IDLE);
            if (w_err_inc) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_req_ready  = w_grant;
    assign o_exe_a      = r_exe_a;
    assign o_exe_b      = r_exe_b;
    assign o_exe_op     = r_exe_op;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_id     = r_id;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_status = r_rsp_status;
    assign o_busy       = r_busy;
    assign o_err_cnt    = r_err_cnt;

endmodule
